multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage.
- Its result and exception flag feed the writeback/result register: data_result drives that register's d, and data_resultRDY drives its en.
- One operation in flight at a time, with a fixed latency of 33 clocks from the start pulse to the ready pulse.
- The processor stalls on the ready pulse.

Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported.
- ITER, 32: number of iteration cycles. Equal to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_MULT  input  1  one-cycle start pulse for a multiply.
- ctrl_DIV  input  1  one-cycle start pulse for a divide.
- data_operandA  input  32  multiplicand or dividend (two's complement), sampled only on a start edge.
- data_operandB  input  32  multiplier or divisor (two's complement), sampled only on a start edge.
- data_result  output  32  low 32 bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero flag.
- data_resultRDY  output  1  one-cycle pulse; data_result and data_exception are valid while it is high.

Behaviour:
- Reset: reset is synchronous and active-high on clk.
  - Reset has priority over everything.
  - Next edge: state goes to IDLE and the counter is cleared.
  - data_result = 0, data_exception = 0, data_resultRDY = 0.
  - An operation in flight is discarded; no RDY pulse is produced for it.
- States: IDLE, MUL, DIV, DONE.
- Start:
  - On any edge where ctrl_MULT or ctrl_DIV is 1: latch A and B, latch the operand signs, clear the counter, go to MUL or DIV.
  - This applies in any state, including mid-operation: the current operation is aborted and restarted with the new operands.
  - If both ctrl signals are 1 on the same edge, MULT wins.
- MUL:
  - Unsigned shift-add on |A| and |B|, one multiplier bit per cycle, 32 cycles, building a 64-bit product.
  - Final product is negated if sign(A) xor sign(B).
- DIV:
  - Restoring division on |A| and |B|, one quotient bit per cycle, 32 cycles.
  - Quotient is negated if the signs differ, truncating toward zero. The remainder is discarded.
- Counter: 6 bits, increments each iteration cycle.
  - When it reaches ITER-1, the next state is DONE.
- DONE:
  - Lasts one cycle with data_resultRDY = 1; next state is IDLE unless a new start arrives.
  - RDY is high in the cycle after the 33rd edge following the start edge.
- Holding outputs:
  - data_result and data_exception update only on entry to DONE.
  - They hold until the next DONE or reset.
  - Intermediate iteration values are never visible on the outputs.
- Multiply exception: 1 if the 64-bit signed product's bits [63:31] are not all equal. data_result is still the low 32 bits.
- Divide by zero (B = 0):
  - Detected at start; iterations still run so latency stays uniform.
  - data_result = 0, data_exception = 1.
- Divide overflow: 0x80000000 / 0xFFFFFFFF gives data_result = 0x80000000, data_exception = 1.
- Edge operand: |0x80000000| = 2^31, which fits the unsigned 32-bit datapath; no special casing.
- While busy: the operand inputs are ignored except on start edges.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE/MUL/DIV/DONE);
  - the WIDTH and ITER constants;
  - the counter width, which is 6.
- One sub-module: iter_counter, a 6-bit synchronous counter.
  - Inputs: clk, reset, clear, en.
  - Outputs: count, last (count == ITER-1).
- The datapath and FSM stay in multdiv_iter.

Test Plan:
- Signed multiply: ctrl_MULT with A=7, B=-6 (0xFFFFFFFA) -> RDY exactly 33 edges later for one cycle; result 0xFFFFFFD6; exception 0.
- Multiply overflow: A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. Also A=0x80000000, B=1 -> result 0x80000000, exception 0.
- Signed divide: ctrl_DIV with A=-100, B=7 -> result 0xFFFFFFF2 (-14), exception 0. Also A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- Divide by zero: A=5, B=0 -> RDY after 33 edges; result 0, exception 1. The next operation, 6/3, then gives result 2, exception 0.
- Restart mid-operation: MULT 3*4, then DIV 20/5 issued 10 cycles later -> exactly one RDY, 33 edges after the DIV start; result 4. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 -> result 18.
- Reset: assert reset 15 cycles into a DIV -> outputs 0 on the next edge, no RDY pulse, and a following MULT 2*2 returns 4 with normal latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // Two's complement magnitude; 0x80000000 maps to 2^31, which fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Start/operand request and result/exception response of the mult/div unit.
interface multdiv_if;
  import multdiv_pkg::*;

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter for the mult/div unit; flags the final iteration.
// Latency: count updates on the edge after clear/en.
// Backpressure: none; clear overrides en.
module iter_counter
  import multdiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(ITER - 1));

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring).
// Latency: RDY pulses in the cycle after the 33rd edge following the start edge.
// Backpressure: none; a new start aborts and restarts any operation in flight.
module multdiv_iter
  import multdiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  multdiv_if.slave bus
);

  state_t                 state, state_nxt;
  logic                   start, busy, iter_en, last;
  logic                   prep, neg, dz;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       a_q, b_q, op, res_q, fin_res;
  logic                   exc_q, fin_exc;
  logic [2*WIDTH-1:0]     acc, acc_nxt, prod;
  logic [WIDTH:0]         sum, shifted, diff;

  assign start   = bus.ctrl_MULT | bus.ctrl_DIV;
  assign busy    = (state == MUL) || (state == DIV);
  // The first busy cycle forms the operand magnitudes and is not an iteration.
  assign iter_en = busy && !prep && !start;

  iter_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (iter_en),
    .count (cnt),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = IDLE;
      MUL, DIV: if (!prep && last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (bus.ctrl_MULT)     state_nxt = MUL;
    else if (bus.ctrl_DIV) state_nxt = DIV;
  end

  // MUL: acc = {partial high, remaining multiplier}; DIV: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, op};
    if (state == MUL)       acc_nxt = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])  acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else                    acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod = neg ? -acc_nxt : acc_nxt;
    if (state == MUL) begin
      fin_res = prod[WIDTH-1:0];
      fin_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end else begin
      fin_res = dz ? '0 : (neg ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0]);
      fin_exc = dz || (!neg && acc_nxt[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op    <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      dz    <= 1'b0;
      prep  <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else if (start) begin
      a_q  <= bus.data_operandA;
      b_q  <= bus.data_operandB;
      neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dz   <= (bus.data_operandB == '0);
      prep <= 1'b1;
    end else if (busy) begin
      if (prep) begin
        prep <= 1'b0;
        if (state == MUL) begin
          acc <= {{WIDTH{1'b0}}, mag(b_q)};
          op  <= mag(a_q);
        end else begin
          acc <= {{WIDTH{1'b0}}, mag(a_q)};
          op  <= mag(b_q);
        end
      end else begin
        acc <= acc_nxt;
        if (last) begin
          res_q <= fin_res;
          exc_q <= fin_exc;
        end
      end
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state == DONE);

  a_cnt_range: assert property (@(posedge clk) disable iff (reset)
    (busy && !prep) |-> (cnt < CNT_W'(ITER)));

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed self-checking bench for multdiv_iter.
module tb_multdiv_iter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  multdiv_if bus();

  multdiv_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Called at #1 after an edge; returns at #1 after the start edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'hDEADBEEF;
    bus.data_operandB = 32'h0;
  endtask

  task automatic watch(input int maxc, output int lat, output int pulses,
                       output logic [31:0] res, output logic exc);
    lat = 0; pulses = 0; res = '0; exc = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          res = bus.data_result;
          exc = bus.data_exception;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.data_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected %h", bus.data_result, 32'h0); end
    checks++; if (bus.data_exception !== 1'b0) begin fails++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] va[3] = '{32'h00000007, 32'h00010000, 32'h80000000};
    logic [31:0] vb[3] = '{32'hFFFFFFFA, 32'h00010000, 32'h00000001};
    logic [31:0] vr[3] = '{32'hFFFFFFD6, 32'h00000000, 32'h80000000};
    logic        ve[3] = '{1'b0, 1'b1, 1'b0};
    int lat, p; logic [31:0] r; logic e;
    for (int i = 0; i < 3; i++) begin
      start_op(1'b1, 1'b0, va[i], vb[i]);
      watch(40, lat, p, r, e);
      checks++; if (lat != 33) begin fails++; $display("FAIL mult%0d_latency: got %0d expected 33", i, lat); end
      checks++; if (p != 1) begin fails++; $display("FAIL mult%0d_pulses: got %0d expected 1", i, p); end
      checks++; if (r !== vr[i]) begin fails++; $display("FAIL mult%0d_result: got %h expected %h", i, r, vr[i]); end
      checks++; if (e !== ve[i]) begin fails++; $display("FAIL mult%0d_exc: got %b expected %b", i, e, ve[i]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] va[2] = '{32'hFFFFFF9C, 32'h80000000};
    logic [31:0] vb[2] = '{32'h00000007, 32'hFFFFFFFF};
    logic [31:0] vr[2] = '{32'hFFFFFFF2, 32'h80000000};
    logic        ve[2] = '{1'b0, 1'b1};
    int lat, p; logic [31:0] r; logic e;
    for (int i = 0; i < 2; i++) begin
      start_op(1'b0, 1'b1, va[i], vb[i]);
      watch(40, lat, p, r, e);
      checks++; if (lat != 33) begin fails++; $display("FAIL div%0d_latency: got %0d expected 33", i, lat); end
      checks++; if (r !== vr[i]) begin fails++; $display("FAIL div%0d_result: got %h expected %h", i, r, vr[i]); end
      checks++; if (e !== ve[i]) begin fails++; $display("FAIL div%0d_exc: got %b expected %b", i, e, ve[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat, p; logic [31:0] r; logic e;
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    watch(40, lat, p, r, e);
    checks++; if (lat != 33) begin fails++; $display("FAIL divzero_latency: got %0d expected 33", lat); end
    checks++; if (r !== 32'h0) begin fails++; $display("FAIL divzero_result: got %h expected %h", r, 32'h0); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL divzero_exc: got %b expected 1", e); end
    start_op(1'b0, 1'b1, 32'd6, 32'd3);
    watch(40, lat, p, r, e);
    checks++; if (r !== 32'd2) begin fails++; $display("FAIL after_divzero_result: got %h expected %h", r, 32'd2); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL after_divzero_exc: got %b expected 0", e); end
    checks++; if (bus.data_result !== 32'd2) begin fails++; $display("FAIL result_hold: got %h expected %h", bus.data_result, 32'd2); end
  endtask

  task automatic test_restart();
    int lat, p, p0; logic [31:0] r; logic e;
    p0 = 0;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clk);
      #1;
      if (bus.data_resultRDY === 1'b1) p0++;
    end
    start_op(1'b0, 1'b1, 32'd20, 32'd5);
    watch(45, lat, p, r, e);
    checks++; if (p0 + p != 1) begin fails++; $display("FAIL restart_pulses: got %0d expected 1", p0 + p); end
    checks++; if (lat != 33) begin fails++; $display("FAIL restart_latency: got %0d expected 33", lat); end
    checks++; if (r !== 32'd4) begin fails++; $display("FAIL restart_result: got %h expected %h", r, 32'd4); end
  endtask

  task automatic test_both();
    int lat, p; logic [31:0] r; logic e;
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    watch(40, lat, p, r, e);
    checks++; if (lat != 33) begin fails++; $display("FAIL both_latency: got %0d expected 33", lat); end
    checks++; if (r !== 32'd18) begin fails++; $display("FAIL both_result: got %h expected %h", r, 32'd18); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL both_exc: got %b expected 0", e); end
  endtask

  task automatic test_reset_mid();
    int lat, p; logic [31:0] r; logic e;
    start_op(1'b0, 1'b1, 32'd100, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.data_result !== 32'h0) begin fails++; $display("FAIL midreset_result: got %h expected %h", bus.data_result, 32'h0); end
    checks++; if (bus.data_exception !== 1'b0) begin fails++; $display("FAIL midreset_exc: got %b expected 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin fails++; $display("FAIL midreset_rdy: got %b expected 0", bus.data_resultRDY); end
    watch(40, lat, p, r, e);
    checks++; if (p != 0) begin fails++; $display("FAIL midreset_no_pulse: got %0d expected 0", p); end
    start_op(1'b1, 1'b0, 32'd2, 32'd2);
    watch(40, lat, p, r, e);
    checks++; if (lat != 33) begin fails++; $display("FAIL postreset_latency: got %0d expected 33", lat); end
    checks++; if (r !== 32'd4) begin fails++; $display("FAIL postreset_result: got %h expected %h", r, 32'd4); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_restart();
    test_both();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
